mem_burst_reader: RTL and testbench

Streaming read client for the banked single-port memory (`mem_single`, 42 banks × DEPTH words, 17-bit flat address). On a start command it issues consecutive read addresses from `base_addr` for `length` words. It absorbs the memory's one-cycle registered read latency and presents the words on a valid/ready stream with full backpressure. It sits between the memory port and downstream consumers (matrix/column loaders) and is the read-side counterpart to the memory's write/read port.

---
 rtl/mem_pkg.sv | 18 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/mem_burst_reader.sv | 149 ++++++++++++++
 tb/tb_mem_burst_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the banked memory
// and its streaming read client.
package mem_pkg;

  localparam int MEM_WIDTH    = 8;
  localparam int MEM_ADDR_W   = 17;
  localparam int MEM_DEPTH    = 64;
  localparam int MEM_BANKS    = 42;
  localparam int MEM_CAPACITY = MEM_BANKS * MEM_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a write into a
// full FIFO is accepted only when a read frees a slot.
module sync_fifo #(
  parameter int W = 9,
  parameter int D = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [$clog2(D):0] count
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;
  logic          do_wr, do_rd;

  assign full    = (count_q == CW'(D));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + CW'(1);
    if (do_rd && !do_wr) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read client: issues sequential reads, hides the
// one-cycle memory latency and streams words with backpressure.
module mem_burst_reader
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int BANKS      = MEM_BANKS,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_data,
  input  logic [WIDTH-1:0]  mem_q,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(BANKS * DEPTH);
  localparam logic [CW:0] FD = (CW+1)'(FIFO_DEPTH);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [1:0]        v_q, v_d;
  logic [1:0]        l_q, l_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [WIDTH:0]    fifo_rd;
  logic [CW-1:0]     fifo_count;
  logic [1:0]        pending;
  logic [CW:0]       occ;
  logic [ADDR_W:0]   end_addr;
  logic              issue, pop;

  sync_fifo #(
    .W (WIDTH + 1),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (v_q[1]),
    .wr_data ({l_q[1], mem_q}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  assign out_valid   = (fifo_count != '0);
  assign out_data    = out_valid ? fifo_rd[WIDTH-1:0] : '0;
  assign out_last    = out_valid & fifo_rd[WIDTH];
  assign pop         = out_valid & out_ready;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign mem_address = maddr_q;
  assign mem_wr_en   = 1'b0;
  assign mem_data    = '0;

  // In-flight reads reserve FIFO slots so a stall never drops data.
  assign pending  = {1'b0, v_q[0]} + {1'b0, v_q[1]};
  assign occ      = {1'b0, fifo_count} + {{(CW-1){1'b0}}, pending};
  assign issue    = (state_q == S_READ) && (occ < FD);
  assign end_addr = {1'b0, base_addr} + {1'b0, length};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    maddr_d = maddr_q;
    v_d     = {v_q[0], issue};
    l_d     = {l_q[0], issue && (rem_q == ADDR_W'(1))};
    done_d  = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (end_addr > CAP) begin
            error_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          maddr_d = addr_q;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      maddr_q <= '0;
      v_q     <= '0;
      l_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      maddr_q <= maddr_d;
      v_q     <= v_d;
      l_q     <= l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader against a preloaded
// memory model with mem[a] = a[7:0].
module tb_mem_burst_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [16:0] base_addr = '0;
  logic [16:0] length = '0;
  logic        busy, done, error;
  logic [16:0] mem_address;
  logic        mem_wr_en;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  logic [7:0]  mem [2688];
  int          n_vec = 0;
  int          n_bad = 0;

  mem_burst_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_data    (mem_data),
    .mem_q       (mem_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_address < 17'd2688) mem_q <= mem[mem_address];
  end

  typedef struct {
    logic        start;
    logic [16:0] base;
    logic [16:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic [16:0] ma;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic s, input int b, input int l,
                               input logic bu, input logic dn,
                               input logic er, input logic ov,
                               input int od, input logic ol,
                               input int ma);
    vec_t v;
    v.start = s;  v.base = 17'(b); v.len = 17'(l);
    v.busy = bu;  v.done = dn;     v.err = er;
    v.ov = ov;    v.od = 8'(od);   v.ol = ol;
    v.ma = 17'(ma);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_burst(input int b, input int l,
                           input bit rnd, input bit mid);
    int got;
    bit seen_done;
    int exp_d;
    start = 1'b1; base_addr = 17'(b); length = 17'(l);
    tick();
    start = 1'b0;
    got = 0;
    seen_done = 0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid && c == 5) begin
        start = 1'b1; base_addr = 17'd500; length = 17'd3;
      end else begin
        start = 1'b0;
      end
      if (done) seen_done = 1;
      if (!seen_done && out_valid && out_ready) begin
        exp_d = (b + got) & 8'hFF;
        chk($sformatf("burst%0d_data%0d", b, got), 32'(out_data), 32'(exp_d));
        chk($sformatf("burst%0d_last%0d", b, got), 32'(out_last),
            32'(got == l - 1));
        got++;
      end
      if (!seen_done) tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("burst%0d_count", b), 32'(got), 32'(l));
    chk($sformatf("burst%0d_done", b), 32'(seen_done), 32'd1);
    tick();
    chk($sformatf("burst%0d_idle", b), 32'(busy), 32'd0);
  endtask

  initial begin
    int got;
    bit bad_done;
    for (int a = 0; a < 2688; a++) mem[a] = 8'(a);

    // contiguous burst: per-cycle expectations after each edge
    tbl.push_back(mkv(1, 100, 8, 1, 0, 0, 0, 0, 0, 0));
    for (int j = 1; j <= 10; j++)
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, j >= 3,
                        j >= 3 ? 97 + j : 0, j == 10,
                        j <= 8 ? 99 + j : 107));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 107));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 107));
    // out-of-range start
    tbl.push_back(mkv(1, 2680, 9, 0, 0, 1, 0, 0, 0, 107));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 107));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 107));
    // zero length
    tbl.push_back(mkv(1, 0, 0, 1, 1, 0, 0, 0, 0, 107));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 107));

    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_mem_data", 32'(mem_data), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      start = tbl[i].start;
      base_addr = tbl[i].base;
      length = tbl[i].len;
      out_ready = 1'b1;
      tick();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].err));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("v%0d_last", i), 32'(out_last), 32'(tbl[i].ol));
      chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(tbl[i].ma));
      chk($sformatf("v%0d_wr_en", i), 32'(mem_wr_en), 0);
    end
    start = 1'b0;

    run_burst(0, 20, 1, 0);
    run_burst(60, 10, 0, 1);
    run_burst(2670, 18, 1, 0);

    // reset in the middle of a 16-word burst
    start = 1'b1; base_addr = 17'd200; length = 17'd16;
    tick();
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got < 3; c++) begin
      if (out_valid && out_ready) got++;
      tick();
    end
    chk("mid_rst_words", 32'(got), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    chk("mid_rst_addr", 32'(mem_address), 0);
    bad_done = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || out_valid || busy) bad_done = 1;
    end
    chk("mid_rst_quiet", 32'(bad_done), 0);
    run_burst(5, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
